regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the pipelined core, replacing the fixed 2R/1W array. It adds:
- a configurable number of read and write ports;
- write-through bypass, so a read sees data being written in the same cycle;
- a real synchronous reset clear;
- a per-register pending-write scoreboard used by the decode stage to detect RAW hazards on long-latency producers (loads, multi-cycle ops).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers; power of two, >= 4; AW = clog2(NREG) is derived internally
NRP, 2, number of read ports
NWP, 2, number of write ports; port index is priority, highest index wins

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
rd_addr  input  NRP*AW  read addresses; port i occupies bits [i*AW +: AW]
rd_data  output  NRP*XLEN  read data, combinational
rd_busy  output  NRP  register at rd_addr[i] has an outstanding reserved write not satisfied this cycle
wr_en  input  NWP  write enables
wr_addr  input  NWP*AW  write addresses
wr_data  input  NWP*XLEN  write data
rsv_en  input  1  reserve (mark pending) register rsv_addr
rsv_addr  input  AW  register to reserve
busy_vec  output  NREG  registered scoreboard; bit 0 is constant 0
wr_collide  output  1  registered pulse: two or more enabled write ports hit the same nonzero address in the previous cycle

Behaviour:
- Register 0 is hardwired zero:
  - reads of address 0 return 0 and rd_busy 0;
  - writes to 0 are ignored and never bypassed;
  - a reservation of 0 is ignored.
- Reset (rst high at posedge):
  - all NREG entries cleared to 0, busy_vec cleared to 0, wr_collide cleared to 0, in one cycle;
  - writes and reservations in that cycle are dropped.
  - While rst is high, rd_data is all 0 and rd_busy is all 0, i.e. bypass is disabled.
- Read, zero latency:
  - rd_data[i] is the value of the highest-index port j with wr_en[j] and wr_addr[j]==rd_addr[i]!=0;
  - otherwise rd_data[i] is the array value.
- Write: commits at posedge. If several enabled ports target the same address, the highest index wins; lower ones are dropped.
- wr_collide: set at the posedge following a cycle with a same-address (nonzero) write conflict, otherwise 0 at the next edge. It is a one-cycle pulse per conflicting cycle.
- Scoreboard, per register r != 0, at posedge:
  - if rsv_en && rsv_addr==r, busy[r] becomes 1. Reserve wins over a same-cycle write, because a new producer was issued; the array data is still updated.
  - else if any enabled write targets r, busy[r] becomes 0;
  - else busy[r] holds.
- rd_busy[i] = busy[rd_addr[i]] && !(bypass hit on port i). A same-cycle writeback therefore resolves the hazard with zero stall. A same-cycle reservation does not affect rd_busy until the next cycle.
- Reserving an already-busy register keeps it busy; there is no counting. Writes to a non-busy register are legal and leave busy at 0.
- Width rules: addresses are compared on the full AW bits; there is no sign or zero extension of data.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then pulse rst for 1 cycle → rd_data for r5 = 0, busy_vec = 0, wr_collide = 0.
- Bypass and x0: same cycle, wr_en[0] to r7 with 0x12345678, and r0 with 0xFFFFFFFF; read r7 and r0 → rd_data = 0x12345678 and 0 combinationally; next cycle r7 array = 0x12345678, r0 = 0.
- Write priority and collide: port0 writes r3 = 0x1, port1 writes r3 = 0x2 in the same cycle → r3 = 0x2, wr_collide = 1 for exactly the following cycle. Both ports writing r0 → wr_collide stays 0.
- Scoreboard lifecycle:
  - reserve r9 → busy_vec[9] = 1 next cycle, rd_busy = 1 on reads of r9;
  - writeback r9 = 0xA5 → rd_busy = 0 and rd_data = 0xA5 in that same cycle; busy_vec[9] = 0 after the edge.
- Simultaneous reserve and write of r4 (value 0x77) → busy_vec[4] = 1, r4 = 0x77. Reserving r0 → busy_vec[0] stays 0.
- Reset mid-operation: r2 and r6 reserved, and rst is asserted in the same cycle as a write to r2 → after the edge busy_vec = 0 and r2 = 0 (write dropped).

Source files
------------

// File: rtl/regfile_mp_sb_if.sv
// Register file port bundle: read, write and reservation ports.
// Master drives addresses, write data and reservations; slave returns data and scoreboard state.
interface regfile_mp_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [NREG-1:0]     busy_vec;
  logic                wr_collide;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec, wr_collide
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec, wr_collide
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-through bypass and pending-write scoreboard.
// Ports: clk, rst (sync, active high), bus (regfile_mp_sb_if.slave).
module regfile_mp_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 2
) (
  input  logic           clk,
  input  logic           rst,
  regfile_mp_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] wr_hit;
  logic            collide;
  logic            collide_q;

  // Registers targeted by any enabled, nonzero write this cycle.
  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NWP; j++) begin
      if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
        wr_hit[bus.wr_addr[j*AW +: AW]] = 1'b1;
    end
  end

  always_comb begin
    collide = 1'b0;
    for (int j = 0; j < NWP; j++) begin
      for (int k = j + 1; k < NWP; k++) begin
        if (bus.wr_en[j] && bus.wr_en[k] &&
            bus.wr_addr[j*AW +: AW] == bus.wr_addr[k*AW +: AW] &&
            bus.wr_addr[j*AW +: AW] != '0)
          collide = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit;
    logic [XLEN-1:0] byp;

    assign ra = bus.rd_addr[i*AW +: AW];

    // Ascending scan: the highest-index matching port wins.
    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NWP; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == ra) begin
          hit = 1'b1;
          byp = bus.wr_data[j*XLEN +: XLEN];
        end
      end
    end

    assign bus.rd_data[i*XLEN +: XLEN] =
      (rst || ra == '0) ? '0 : (hit ? byp : mem[ra]);
    assign bus.rd_busy[i] =
      !rst && ra != '0 && busy[ra] && !hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        mem[r] <= '0;
      busy      <= '0;
      collide_q <= 1'b0;
    end else begin
      // Later iterations override earlier ones: highest port wins.
      for (int j = 0; j < NWP; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
          mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
      end
      busy[0] <= 1'b0;
      for (int r = 1; r < NREG; r++) begin
        if (bus.rsv_en && bus.rsv_addr == AW'(r))
          busy[r] <= 1'b1;
        else if (wr_hit[r])
          busy[r] <= 1'b0;
      end
      collide_q <= collide;
    end
  end

  assign bus.busy_vec   = busy;
  assign bus.wr_collide = collide_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed testbench for regfile_mp_sb.
// Drives the bus interface, checks bypass, priority, scoreboard and reset.
module tb_regfile_mp_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  regfile_mp_sb_if #(
    .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)
  ) bus ();

  regfile_mp_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a,
                    input logic [XLEN-1:0] d);
    bus.wr_en[p]              = 1'b1;
    bus.wr_addr[p*AW +: AW]   = a;
    bus.wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  task automatic test_reset();
    clr();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    clr();
    rd(0, 5'd5);
    #1;
    vectors++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL pre_reset_r5 got %h exp %h", bus.rd_data[31:0], 32'hDEADBEEF);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL rd_during_rst got %h exp 0", bus.rd_data[31:0]);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_r5 got %h exp 0", bus.rd_data[31:0]);
    end
    vectors++;
    if (bus.busy_vec !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_busy got %h exp 0", bus.busy_vec);
    end
    vectors++;
    if (bus.wr_collide !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_collide got %b exp 0", bus.wr_collide);
    end
  endtask

  task automatic test_bypass_x0();
    clr();
    wr(0, 5'd7, 32'h12345678);
    wr(1, 5'd0, 32'hFFFFFFFF);
    rd(0, 5'd7);
    rd(1, 5'd0);
    #1;
    vectors++;
    if (bus.rd_data[31:0] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL bypass_r7 got %h exp %h", bus.rd_data[31:0], 32'h12345678);
    end
    vectors++;
    if (bus.rd_data[63:32] !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_r0 got %h exp 0", bus.rd_data[63:32]);
    end
    tick();
    clr();
    rd(0, 5'd7);
    rd(1, 5'd0);
    #1;
    vectors++;
    if (bus.rd_data[31:0] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL array_r7 got %h exp %h", bus.rd_data[31:0], 32'h12345678);
    end
    vectors++;
    if (bus.rd_data[63:32] !== 32'h0) begin
      miscompares++;
      $display("FAIL array_r0 got %h exp 0", bus.rd_data[63:32]);
    end
  endtask

  task automatic test_priority_collide();
    clr();
    wr(0, 5'd3, 32'h1);
    wr(1, 5'd3, 32'h2);
    rd(1, 5'd3);
    #1;
    vectors++;
    if (bus.rd_data[63:32] !== 32'h2) begin
      miscompares++;
      $display("FAIL prio_bypass got %h exp 2", bus.rd_data[63:32]);
    end
    tick();
    clr();
    rd(0, 5'd3);
    #1;
    vectors++;
    if (bus.rd_data[31:0] !== 32'h2) begin
      miscompares++;
      $display("FAIL prio_r3 got %h exp 2", bus.rd_data[31:0]);
    end
    vectors++;
    if (bus.wr_collide !== 1'b1) begin
      miscompares++;
      $display("FAIL collide_set got %b exp 1", bus.wr_collide);
    end
    tick();
    vectors++;
    if (bus.wr_collide !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_pulse got %b exp 0", bus.wr_collide);
    end
    wr(0, 5'd0, 32'h5);
    wr(1, 5'd0, 32'h6);
    tick();
    clr();
    vectors++;
    if (bus.wr_collide !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_r0 got %b exp 0", bus.wr_collide);
    end
    wr(0, 5'd10, 32'h1);
    wr(1, 5'd11, 32'h2);
    tick();
    clr();
    vectors++;
    if (bus.wr_collide !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_diff got %b exp 0", bus.wr_collide);
    end
  endtask

  task automatic test_scoreboard();
    clr();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd9;
    rd(0, 5'd9);
    #1;
    vectors++;
    if (bus.rd_busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rsv_same_cycle got %b exp 0", bus.rd_busy[0]);
    end
    tick();
    clr();
    rd(0, 5'd9);
    #1;
    vectors++;
    if (bus.busy_vec[9] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy9_set got %b exp 1", bus.busy_vec[9]);
    end
    vectors++;
    if (bus.rd_busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_busy9 got %b exp 1", bus.rd_busy[0]);
    end
    wr(1, 5'd9, 32'hA5);
    #1;
    vectors++;
    if (bus.rd_busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL wb_rd_busy got %b exp 0", bus.rd_busy[0]);
    end
    vectors++;
    if (bus.rd_data[31:0] !== 32'hA5) begin
      miscompares++;
      $display("FAIL wb_bypass got %h exp a5", bus.rd_data[31:0]);
    end
    tick();
    clr();
    rd(0, 5'd9);
    #1;
    vectors++;
    if (bus.busy_vec[9] !== 1'b0) begin
      miscompares++;
      $display("FAIL busy9_clr got %b exp 0", bus.busy_vec[9]);
    end
    vectors++;
    if (bus.rd_data[31:0] !== 32'hA5) begin
      miscompares++;
      $display("FAIL r9_array got %h exp a5", bus.rd_data[31:0]);
    end
  endtask

  task automatic test_rsv_write();
    clr();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd4;
    wr(0, 5'd4, 32'h77);
    tick();
    clr();
    rd(0, 5'd4);
    #1;
    vectors++;
    if (bus.busy_vec[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL rsv_wins got %b exp 1", bus.busy_vec[4]);
    end
    vectors++;
    if (bus.rd_data[31:0] !== 32'h77) begin
      miscompares++;
      $display("FAIL rsv_wr_data got %h exp 77", bus.rd_data[31:0]);
    end
    vectors++;
    if (bus.rd_busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rsv_rd_busy got %b exp 1", bus.rd_busy[0]);
    end
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd0;
    tick();
    clr();
    vectors++;
    if (bus.busy_vec !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL rsv_r0 got %h exp 00000010", bus.busy_vec);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd2;
    tick();
    bus.rsv_addr = 5'd6;
    tick();
    clr();
    vectors++;
    if (bus.busy_vec !== 32'h0000_0054) begin
      miscompares++;
      $display("FAIL mid_busy_pre got %h exp 00000054", bus.busy_vec);
    end
    rst = 1'b1;
    wr(0, 5'd2, 32'h55);
    rd(0, 5'd2);
    rd(1, 5'd6);
    #1;
    vectors++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_rst_bypass got %h exp 0", bus.rd_data[31:0]);
    end
    vectors++;
    if (bus.rd_busy !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_rst_rd_busy got %b exp 00", bus.rd_busy);
    end
    tick();
    rst = 1'b0;
    clr();
    rd(0, 5'd2);
    #1;
    vectors++;
    if (bus.busy_vec !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_busy_post got %h exp 0", bus.busy_vec);
    end
    vectors++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_r2 got %h exp 0", bus.rd_data[31:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    test_reset();
    test_bypass_x0();
    test_priority_collide();
    test_scoreboard();
    test_rsv_write();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
